// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encoding, FSM state type and counter sizing for muldiv_seq
package muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Step counter width for a W-step operation (counts 0..W-1).
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 step: shift-add multiply or restoring-divide compare-subtract
//
// Ports:
//   i_op  : OP_MUL / OP_DIV
//   i_hi  : multiply: upper accumulator half      divide: partial remainder
//   i_lo  : multiply: remaining multiplier bits   divide: dividend bits / quotient bits
//   i_opd : multiply: multiplicand                divide: divisor
//   o_hi  : next i_hi
//   o_lo  : next i_lo
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         i_op,
    input  logic [W-1:0] i_hi,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_opd,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole 2W-bit accumulator right.
    // The sum's LSB drops into the top of the low half as a product bit.
    logic [W:0] w_sum;
    assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opd} : {(W+1){1'b0}});

    // Divide: shift the next dividend bit (MSB of i_lo) into the partial
    // remainder. The trial difference only matters when w_tr >= divisor, in
    // which case it is below the divisor and fits W bits.
    logic [W:0]   w_tr;
    logic         w_ge;
    logic [W-1:0] w_diff;
    assign w_tr   = {i_hi, i_lo[W-1]};
    assign w_ge   = (w_tr >= {1'b0, i_opd});
    assign w_diff = w_tr[W-1:0] - i_opd;

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        if (i_op == OP_MUL) begin
            o_hi = w_sum[W:1];
            o_lo = {w_sum[0], i_lo[W-1:1]};
        end else begin
            o_hi = w_ge ? w_diff : w_tr[W-1:0];
            o_lo = {i_lo[W-2:0], w_ge};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential radix-2 multiply / divide / modulus unit, one step per clock
//
// Optional feature macro: MULDIV_SIGNED_EN (adds input sgn for two's complement operands).
//
// Ports:
//   t     : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, accepted when busy=0
//   op    : 0 multiply, 1 divide/modulus (sampled with start)
//   a, b  : multiplicand/dividend, multiplier/divisor (sampled with start)
//   sgn   : (MULDIV_SIGNED_EN only) operands are two's complement
//   busy  : operation in progress
//   done  : one-cycle completion pulse
//   p     : 2W-bit product
//   q,rem : quotient, remainder
//   dz    : divisor was zero
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int W = 10
) (
    input  logic           t,
    input  logic           rst,
    input  logic           start,
    input  logic           op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef MULDIV_SIGNED_EN
    input  logic           sgn,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p,
    output logic [W-1:0]   q,
    output logic [W-1:0]   rem,
    output logic           dz
);

    localparam int CW = cnt_w(W);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_op;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_opd;
    logic           r_bz;
    logic           r_neg_res;
    logic           r_neg_rem;

    // Operand signs; the core always works on magnitudes.
    logic w_sa;
    logic w_sb;
`ifdef MULDIV_SIGNED_EN
    assign w_sa = sgn & a[W-1];
    assign w_sb = sgn & b[W-1];
`else
    assign w_sa = 1'b0;
    assign w_sb = 1'b0;
`endif

    logic [W-1:0] w_a_mag;
    logic [W-1:0] w_b_mag;
    assign w_a_mag = w_sa ? (~a + 1'b1) : a;
    assign w_b_mag = w_sb ? (~b + 1'b1) : b;

    logic [W-1:0] w_hi_n;
    logic [W-1:0] w_lo_n;

    muldiv_step #(.W(W)) u_step (
        .i_op  (r_op),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .i_opd (r_opd),
        .o_hi  (w_hi_n),
        .o_lo  (w_lo_n)
    );

    // Final-step results, sign-corrected in the completion cycle.
    logic [2*W-1:0] w_p_mag;
    assign w_p_mag = {w_hi_n, w_lo_n};

    always_ff @(posedge t or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_op      <= OP_MUL;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opd     <= '0;
            r_bz      <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            p         <= '0;
            q         <= '0;
            rem       <= '0;
            dz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_cnt     <= '0;
                        r_hi      <= '0;
                        // Multiply consumes the multiplier from the low half;
                        // divide shifts the dividend out of it.
                        r_lo      <= (op == OP_MUL) ? w_b_mag : w_a_mag;
                        r_opd     <= (op == OP_MUL) ? w_a_mag : w_b_mag;
                        r_bz      <= (b == '0);
                        r_neg_res <= w_sa ^ w_sb;
                        r_neg_rem <= w_sa;
                        busy      <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_hi <= w_hi_n;
                    r_lo <= w_lo_n;
                    if (r_cnt == CW'(W-1)) begin
                        if (r_op == OP_MUL) begin
                            p <= r_neg_res ? (~w_p_mag + 1'b1) : w_p_mag;
                        end else begin
                            q   <= r_neg_res ? (~w_lo_n + 1'b1) : w_lo_n;
                            rem <= r_neg_rem ? (~w_hi_n + 1'b1) : w_hi_n;
                            dz  <= r_bz;
                        end
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard testbench for muldiv_seq with directed W=10 vectors
module tb_muldiv_seq;

    localparam int W = 10;

    logic           t = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           op = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
`ifdef MULDIV_SIGNED_EN
    logic           sgn = 1'b0;
`endif
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;
    logic [W-1:0]   q;
    logic [W-1:0]   rem;
    logic           dz;

    muldiv_seq #(.W(W)) dut (
        .t     (t),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
`ifdef MULDIV_SIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .p     (p),
        .q     (q),
        .rem   (rem),
        .dz    (dz)
    );

    always #5 t = ~t;

    int cyc = 0;
    always @(posedge t) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2*W-1:0] p;
        logic [W-1:0]   q;
        logic [W-1:0]   rem;
        logic           dz;
        int             cyc;
    } exp_t;

    exp_t sb[$];

    logic [2*W-1:0] m_p   = '0;
    logic [W-1:0]   m_q   = '0;
    logic [W-1:0]   m_rem = '0;
    logic           m_dz  = 1'b0;
    int             busy_run = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge t) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("p", p, e.p);
                    chk("q", q, e.q);
                    chk("rem", rem, e.rem);
                    chk("dz", dz, e.dz);
                    chk("busy_with_done", busy, 0);
                    chk("busy_cycles", busy_run, W);
                end
                busy_run = 0;
            end
        end
    end

    // Called just after a negedge; drives a start and queues its expected result.
    task automatic issue(input logic i_op, input logic [W-1:0] i_a, input logic [W-1:0] i_b,
                         input logic i_sgn, input logic [2*W-1:0] e_p,
                         input logic [W-1:0] e_q, input logic [W-1:0] e_rem, input logic e_dz);
        exp_t e;
        op    = i_op;
        a     = i_a;
        b     = i_b;
`ifdef MULDIV_SIGNED_EN
        sgn   = i_sgn;
`else
        if (i_sgn) $display("signed vector skipped");
`endif
        start = 1'b1;
        if (i_op == 1'b0) begin
            m_p = e_p;
        end else begin
            m_q   = e_q;
            m_rem = e_rem;
            m_dz  = e_dz;
        end
        e.p   = m_p;
        e.q   = m_q;
        e.rem = m_rem;
        e.dz  = m_dz;
        e.cyc = cyc + 1 + W;
        sb.push_back(e);
    endtask

    task automatic go(input logic i_op, input logic [W-1:0] i_a, input logic [W-1:0] i_b,
                      input logic i_sgn, input logic [2*W-1:0] e_p,
                      input logic [W-1:0] e_q, input logic [W-1:0] e_rem, input logic e_dz);
        issue(i_op, i_a, i_b, i_sgn, e_p, e_q, e_rem, e_dz);
        @(negedge t);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge t);
        @(negedge t);
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_p"}, p, 0);
        chk({tag, "_q"}, q, 0);
        chk({tag, "_rem"}, rem, 0);
        chk({tag, "_dz"}, dz, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge t);
        chk_zero("in_reset");
        rst = 1'b0;
        @(negedge t);
        chk_zero("after_reset");

        // Multiply then divides; unrelated results must hold.
        go(1'b0, 10'd517, 10'd141, 1'b0, 20'd72897, 10'd0, 10'd0, 1'b0);
        wait_idle();
        go(1'b1, 10'd1000, 10'd139, 1'b0, 20'd0, 10'd7, 10'd27, 1'b0);
        wait_idle();
        go(1'b1, 10'd613, 10'd0, 1'b0, 20'd0, 10'd1023, 10'd613, 1'b1);
        wait_idle();
        go(1'b1, 10'd5, 10'd7, 1'b0, 20'd0, 10'd0, 10'd5, 1'b0);
        wait_idle();
        go(1'b1, 10'd1023, 10'd1, 1'b0, 20'd0, 10'd1023, 10'd0, 1'b0);
        wait_idle();
        go(1'b0, 10'd0, 10'd1023, 1'b0, 20'd0, 10'd0, 10'd0, 1'b0);
        wait_idle();

        // Max operands, ignored start mid-flight, then a start in the done cycle.
        go(1'b0, 10'd1023, 10'd1023, 1'b0, 20'd1046529, 10'd0, 10'd0, 1'b0);
        repeat (3) @(negedge t);
        a = 10'd2;
        b = 10'd3;
        start = 1'b1;
        @(negedge t);
        start = 1'b0;
        repeat (6) @(negedge t);
        chk("done_in_done_cycle", done, 1);
        go(1'b0, 10'd2, 10'd3, 1'b0, 20'd6, 10'd0, 10'd0, 1'b0);
        wait_idle();

        // Make q/rem nonzero before the abort so the reset clear is visible.
        go(1'b1, 10'd900, 10'd7, 1'b0, 20'd0, 10'd128, 10'd4, 1'b0);
        wait_idle();

        // Abort mid-operation with reset.
        op = 1'b0;
        a = 10'd100;
        b = 10'd100;
        start = 1'b1;
        @(negedge t);
        start = 1'b0;
        repeat (4) @(negedge t);
        rst = 1'b1;
        #1;
        chk_zero("abort");
        m_p = '0;
        m_q = '0;
        m_rem = '0;
        m_dz = 1'b0;
        @(negedge t);
        rst = 1'b0;
        repeat (15) @(negedge t);
        go(1'b0, 10'd25, 10'd40, 1'b0, 20'd1000, 10'd0, 10'd0, 1'b0);
        wait_idle();

`ifdef MULDIV_SIGNED_EN
        // -7 / 2 = -3 r -1 ; -3 * 5 = -15 ; -512 / -1 = -512 r 0
        go(1'b1, 10'd1017, 10'd2, 1'b1, 20'd0, 10'd1021, 10'd1023, 1'b0);
        wait_idle();
        go(1'b0, 10'd1021, 10'd5, 1'b1, 20'd1048561, 10'd0, 10'd0, 1'b0);
        wait_idle();
        go(1'b1, 10'd512, 10'd1023, 1'b1, 20'd0, 10'd512, 10'd0, 1'b0);
        wait_idle();
        go(1'b1, 10'd7, 10'd1022, 1'b1, 20'd0, 10'd1021, 10'd1, 1'b0);
        wait_idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
